regfile_sb: RTL and testbench

- Parametrised successor to the core's 2-read/1-write integer register file.
- Adds configurable width and depth, a hardwired-zero x0, and write-to-read bypass.
- Adds a read-enable stall hold, synchronous reset to architectural init values, and a per-register busy scoreboard for issue-stage hazard detection.
- Sits between decode/issue (read and allocate) and writeback (write) in the pipeline.

---
 rtl/rf_pkg.sv | 31 +++
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/regfile_sb.sv | 101 ++++++++++
 tb/tb_regfile_sb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants and types for the scoreboarded register file
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEM_DEPTH
`define MEM_DEPTH 32'h0001_0000
`endif

package rf_pkg;

    // Architectural register indices with fixed roles
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;

    // Default geometry
    localparam int RF_XLEN_DEFAULT  = 32;
    localparam int RF_NREGS_DEFAULT = 32;
    localparam int RF_AW_DEFAULT    = $clog2(RF_NREGS_DEFAULT);

    // Stack pointer sits just above the top of the data memory
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0100_0000 + `MEM_DEPTH;

    // Register index for the default geometry
    typedef logic [RF_AW_DEFAULT-1:0] reg_idx_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register busy bits for issue-stage hazard detection
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int   NREGS    = RF_NREGS_DEFAULT,
    parameter bit   ZERO_REG = 1'b1,
    localparam int  AW       = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          write_enable,
    input  logic [AW-1:0] addr_rd,
    input  logic          alloc_valid,
    input  logic [AW-1:0] alloc_rd,
    input  logic [AW-1:0] addr_rs1,
    input  logic [AW-1:0] addr_rs2,
    output logic          busy_rs1,
    output logic          busy_rs2
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;

    // Next busy vector: writeback clears, allocation sets afterwards so a new
    // producer on the same register supersedes the retiring one
    always_comb begin
        w_busy_next = r_busy;
        if (write_enable) begin
            w_busy_next[addr_rd] = 1'b0;
        end
        if (alloc_valid) begin
            w_busy_next[alloc_rd] = 1'b1;
        end
        if (ZERO_REG) begin
            w_busy_next[REG_ZERO] = 1'b0;
        end
    end

    // Busy vector register, cleared on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // A writeback landing this cycle already resolves the hazard, matching
    // the forwarding path in the read muxes
    assign busy_rs1 = r_busy[addr_rs1] & ~(write_enable & (addr_rd == addr_rs1));
    assign busy_rs2 = r_busy[addr_rs2] & ~(write_enable & (addr_rd == addr_rs2));

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : 2R/1W register file with x0, bypass, stall hold and scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb
    import rf_pkg::*;
#(
    parameter int              XLEN     = RF_XLEN_DEFAULT,
    parameter int              NREGS    = RF_NREGS_DEFAULT,
    parameter logic [XLEN-1:0] SP_INIT  = XLEN'(SP_INIT_DEFAULT),
    parameter bit              BYPASS   = 1'b1,
    parameter bit              ZERO_REG = 1'b1,
    localparam int             AW       = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            read_enable,
    input  logic [AW-1:0]   addr_rs1,
    input  logic [AW-1:0]   addr_rs2,
    output logic [XLEN-1:0] R_data_rs1,
    output logic [XLEN-1:0] R_data_rs2,
    input  logic            write_enable,
    input  logic [AW-1:0]   addr_rd,
    input  logic [XLEN-1:0] data_rd,
    input  logic            alloc_valid,
    input  logic [AW-1:0]   alloc_rd,
    output logic            busy_rs1,
    output logic            busy_rs2
);

    // Flop array so the whole file can be reset to architectural values
    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_wr_commit;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    assign w_wr_commit = write_enable & ~(ZERO_REG && (addr_rd == AW'(REG_ZERO)));

    // Read muxes: zero register first, then optional same-cycle forwarding
    always_comb begin
        w_rd1 = r_regs[addr_rs1];
        w_rd2 = r_regs[addr_rs2];
        if (BYPASS && write_enable && (addr_rd == addr_rs1)) begin
            w_rd1 = data_rd;
        end
        if (BYPASS && write_enable && (addr_rd == addr_rs2)) begin
            w_rd2 = data_rd;
        end
        if (ZERO_REG && (addr_rs1 == AW'(REG_ZERO))) begin
            w_rd1 = '0;
        end
        if (ZERO_REG && (addr_rs2 == AW'(REG_ZERO))) begin
            w_rd2 = '0;
        end
    end

    // Register storage with architectural reset values
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == REG_SP) ? SP_INIT : '0;
            end
        end else if (w_wr_commit) begin
            r_regs[addr_rd] <= data_rd;
        end
    end

    // Registered read data, held while the pipeline is stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            R_data_rs1 <= '0;
            R_data_rs2 <= '0;
        end else if (read_enable) begin
            R_data_rs1 <= w_rd1;
            R_data_rs2 <= w_rd2;
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .addr_rd      (addr_rd),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .addr_rs1     (addr_rs1),
        .addr_rs2     (addr_rs2),
        .busy_rs1     (busy_rs1),
        .busy_rs2     (busy_rs2)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed bench for regfile_sb, BYPASS=1 and BYPASS=0 side by side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEM_DEPTH
`define MEM_DEPTH 32'h0001_0000
`endif

module tb_regfile_sb;

    localparam logic [31:0] SP_EXP = 32'h0100_0000 + `MEM_DEPTH;

    logic        clock = 1'b0;
    logic        reset;
    logic        read_enable;
    logic [4:0]  addr_rs1, addr_rs2, addr_rd, alloc_rd;
    logic        write_enable, alloc_valid;
    logic [31:0] data_rd;

    logic [31:0] r1_b, r2_b, r1_nb, r2_nb;
    logic        b1_b, b2_b, b1_nb, b2_nb;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    regfile_sb #(.BYPASS(1'b1)) dut_b (
        .clock(clock), .reset(reset), .read_enable(read_enable),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .R_data_rs1(r1_b), .R_data_rs2(r2_b),
        .write_enable(write_enable), .addr_rd(addr_rd), .data_rd(data_rd),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .busy_rs1(b1_b), .busy_rs2(b2_b)
    );

    regfile_sb #(.BYPASS(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .read_enable(read_enable),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .R_data_rs1(r1_nb), .R_data_rs2(r2_nb),
        .write_enable(write_enable), .addr_rd(addr_rd), .data_rd(data_rd),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .busy_rs1(b1_nb), .busy_rs2(b2_nb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: register values, pending-write set, read results
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] m_r1_b, m_r2_b, m_r1_nb, m_r2_nb;
    bit          model_ok = 0;

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit fwd);
        if (a == 5'd0)                        return 32'h0;
        if (fwd && write_enable && addr_rd == a) return data_rd;
        return m_regs[a];
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 0;
            end
            m_regs[2] = SP_EXP;
            m_r1_b = 0; m_r2_b = 0; m_r1_nb = 0; m_r2_nb = 0;
            model_ok = 1;
        end else begin
            if (read_enable) begin
                m_r1_b  = model_read(addr_rs1, 1);
                m_r2_b  = model_read(addr_rs2, 1);
                m_r1_nb = model_read(addr_rs1, 0);
                m_r2_nb = model_read(addr_rs2, 0);
            end
            if (write_enable && addr_rd != 5'd0) m_regs[addr_rd] = data_rd;
            if (write_enable) m_busy[addr_rd] = 0;
            if (alloc_valid && alloc_rd != 5'd0) m_busy[alloc_rd] = 1;
        end
    end

    function automatic bit model_busy(input logic [4:0] a);
        return m_busy[a] && !(write_enable && addr_rd == a);
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (model_ok) begin
            check("cyc_r1_b",  r1_b,  m_r1_b);
            check("cyc_r2_b",  r2_b,  m_r2_b);
            check("cyc_r1_nb", r1_nb, m_r1_nb);
            check("cyc_r2_nb", r2_nb, m_r2_nb);
            check("cyc_busy1_b",  {31'b0, b1_b},  {31'b0, model_busy(addr_rs1)});
            check("cyc_busy2_b",  {31'b0, b2_b},  {31'b0, model_busy(addr_rs2)});
            check("cyc_busy1_nb", {31'b0, b1_nb}, {31'b0, model_busy(addr_rs1)});
            check("cyc_busy2_nb", {31'b0, b2_nb}, {31'b0, model_busy(addr_rs2)});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1; read_enable = 0; write_enable = 0; alloc_valid = 0;
        addr_rs1 = 0; addr_rs2 = 0; addr_rd = 0; alloc_rd = 0; data_rd = 0;
        tick();
        tick();
        // Reset values
        reset = 0; read_enable = 1; addr_rs1 = 0; addr_rs2 = 1;
        #1;
        check("rst_busy1", {31'b0, b1_b}, 32'h0);
        check("rst_busy2", {31'b0, b2_b}, 32'h0);
        tick();
        check("rst_x0", r1_b, 32'h0);
        check("rst_x1", r2_b, 32'h0);
        addr_rs1 = 2;
        tick();
        check("rst_sp", r1_b, SP_EXP);
        check("rst_sp_nb", r1_nb, SP_EXP);

        // Plain write then read
        write_enable = 1; addr_rd = 5; data_rd = 32'hDEADBEEF;
        tick();
        write_enable = 0; addr_rs1 = 5;
        tick();
        check("wr_x5", r1_b, 32'hDEADBEEF);
        check("wr_x5_nb", r1_nb, 32'hDEADBEEF);

        // Same-cycle collision on both ports
        write_enable = 1; addr_rd = 7; data_rd = 32'h1234; addr_rs1 = 7; addr_rs2 = 7;
        tick();
        write_enable = 0;
        check("byp_rs1", r1_b, 32'h1234);
        check("byp_rs2", r2_b, 32'h1234);
        check("nobyp_rs1", r1_nb, 32'h0);
        check("nobyp_rs2", r2_nb, 32'h0);
        tick();
        check("after_byp_nb", r1_nb, 32'h1234);

        // Zero register: write, alloc and read in the same cycle
        write_enable = 1; addr_rd = 0; data_rd = 32'hFFFFFFFF;
        alloc_valid = 1; alloc_rd = 0; addr_rs1 = 0; addr_rs2 = 5;
        tick();
        check("x0_byp", r1_b, 32'h0);
        check("x0_nb", r1_nb, 32'h0);
        write_enable = 0; alloc_valid = 0;
        #1;
        check("x0_busy", {31'b0, b1_b}, 32'h0);
        tick();
        check("x0_read", r1_b, 32'h0);

        // Scoreboard: alloc x9, alloc x10 while writing x11
        alloc_valid = 1; alloc_rd = 9;
        tick();
        alloc_rd = 10; write_enable = 1; addr_rd = 11; data_rd = 32'h11;
        tick();
        alloc_valid = 0; write_enable = 0; addr_rs1 = 9; addr_rs2 = 10;
        #1;
        check("busy_x9", {31'b0, b1_b}, 32'h1);
        check("busy_x10", {31'b0, b2_b}, 32'h1);
        // Write and re-alloc x9 together: clear visible now, set wins next cycle
        write_enable = 1; addr_rd = 9; data_rd = 32'h99; alloc_valid = 1; alloc_rd = 9;
        #1;
        check("busy_x9_wb_comb", {31'b0, b1_b}, 32'h0);
        tick();
        write_enable = 0; alloc_valid = 0;
        #1;
        check("busy_x9_realloc", {31'b0, b1_b}, 32'h1);
        write_enable = 1; addr_rd = 9; data_rd = 32'h9A;
        #1;
        check("busy_x9_clr_comb", {31'b0, b1_b}, 32'h0);
        tick();
        write_enable = 0;
        #1;
        check("busy_x9_clr", {31'b0, b1_b}, 32'h0);
        // Write to a non-busy register leaves it non-busy
        write_enable = 1; addr_rd = 12; data_rd = 32'h12; addr_rs2 = 12;
        tick();
        write_enable = 0;
        #1;
        check("busy_x12", {31'b0, b2_b}, 32'h0);

        // Stall hold, then reset mid-stall with a write and alloc pending
        write_enable = 1; addr_rd = 3; data_rd = 32'h55;
        tick();
        write_enable = 0; addr_rs1 = 3; addr_rs2 = 9;
        tick();
        check("stall_pre", r1_b, 32'h55);
        read_enable = 0; write_enable = 1; addr_rd = 3; data_rd = 32'hAA;
        tick();
        write_enable = 0; alloc_valid = 1; alloc_rd = 4;
        tick();
        check("stall_hold", r1_b, 32'h55);
        check("stall_hold_nb", r1_nb, 32'h55);
        reset = 1; write_enable = 1; addr_rd = 3; data_rd = 32'hBB; alloc_rd = 10;
        tick();
        reset = 0; write_enable = 0; alloc_valid = 0; addr_rs2 = 10;
        #1;
        check("mid_rst_r1", r1_b, 32'h0);
        check("mid_rst_busy10", {31'b0, b2_b}, 32'h0);
        read_enable = 1; addr_rs1 = 3; addr_rs2 = 2;
        tick();
        check("mid_rst_x3", r1_b, 32'h0);
        check("mid_rst_sp", r2_b, SP_EXP);
        addr_rs1 = 4;
        #1;
        check("mid_rst_busy4", {31'b0, b1_b}, 32'h0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
